// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: two-deep stereo sample FIFO feeding an I2S transmitter slaved
// to codec-supplied bclk/lrclk. Everything runs on clk; bclk and lrclk are
// synchronized and edge-detected, and sdata is launched on bclk falling edges
// with the standard one-bclk I2S delay after each lrclk transition.
// Ports:
//   clk, resetn            system clock, async active-low reset
//   bclk, lrclk            codec bit / word clocks (asynchronous inputs)
//   sdata                  registered I2S serial data to the codec
//   in_left, in_right      signed stereo sample pair
//   in_valid, in_ready     upstream handshake (pair accepted on valid && ready)
//   frame_strobe           one-clk pulse when a left word is loaded
//   underrun_count         saturating count of frames sent without a fresh pair
module i2s_tx_fifo #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned CNTSIZE = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               bclk,
  input  logic               lrclk,
  output logic               sdata,
  input  logic [BITSIZE-1:0] in_left,
  input  logic [BITSIZE-1:0] in_right,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               frame_strobe,
  output logic [CNTSIZE-1:0] underrun_count
);

  localparam int unsigned PW = 2 * BITSIZE;
  localparam int unsigned CW = $clog2(BITSIZE + 1);

  // Synchronizer chains: [0] and [1] are the 2-flop synchronizer, [2] the delay flop.
  logic [2:0]         bclk_sync_q, bclk_sync_d;
  logic [2:0]         lr_sync_q, lr_sync_d;
  logic [1:0]         prime_q, prime_d;
  logic [PW-1:0]      mem_q [2];
  logic [PW-1:0]      mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               in_ready_q, in_ready_d;
  logic               armed_q, armed_d;
  logic               started_q, started_d;
  logic [PW-1:0]      held_q, held_d;
  logic [BITSIZE-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic               sdata_q, sdata_d;
  logic               strobe_q, strobe_d;
  logic [CNTSIZE-1:0] ucnt_q, ucnt_d;

  logic               edge_en;
  logic               bclk_fall;
  logic               lr_fall;
  logic               lr_rise;
  logic               push;
  logic               pop;
  logic               fifo_nonempty;
  logic [PW-1:0]      fifo_head;

  // Edge detection; suppressed until the delay flop holds a real sample so
  // that a level already present at reset release never looks like an edge.
  always_comb begin
    edge_en       = (prime_q == 2'd3);
    bclk_fall     = edge_en & bclk_sync_q[2] & ~bclk_sync_q[1];
    lr_fall       = edge_en & lr_sync_q[2] & ~lr_sync_q[1];
    lr_rise       = edge_en & started_q & ~lr_sync_q[2] & lr_sync_q[1];
    fifo_nonempty = (occ_q != 2'd0);
    fifo_head     = mem_q[rd_ptr_q];
    push          = in_valid & in_ready_q;
    pop           = lr_fall & fifo_nonempty;
  end

  // Next-state logic for FIFO, frame control and serializer.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], bclk};
    lr_sync_d   = {lr_sync_q[1:0], lrclk};
    prime_d     = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    armed_d     = armed_q;
    started_d   = started_q;
    held_d      = held_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    sdata_d     = sdata_q;
    strobe_d    = lr_fall;
    ucnt_d      = ucnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_left, in_right};
      wr_ptr_d        = ~wr_ptr_q;
      armed_d         = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      held_d   = fifo_head;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    in_ready_d = (occ_d < 2'd2);

    if (lr_fall) begin
      started_d = 1'b1;
      if (!fifo_nonempty && armed_q && !(&ucnt_q)) begin
        ucnt_d = ucnt_q + CNTSIZE'(1);
      end
    end

    // A load takes priority over a coincident bclk edge and truncates any word in flight.
    if (lr_fall) begin
      shreg_d  = fifo_nonempty ? fifo_head[PW-1:BITSIZE] : held_q[PW-1:BITSIZE];
      bitcnt_d = '0;
      sdata_d  = 1'b0;
    end else if (lr_rise) begin
      shreg_d  = held_q[BITSIZE-1:0];
      bitcnt_d = '0;
      sdata_d  = 1'b0;
    end else if (bclk_fall) begin
      if (bitcnt_q < CW'(BITSIZE)) begin
        sdata_d  = shreg_q[BITSIZE-1];
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + CW'(1);
      end else begin
        sdata_d  = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      prime_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      in_ready_q  <= 1'b0;
      armed_q     <= 1'b0;
      started_q   <= 1'b0;
      held_q      <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      sdata_q     <= 1'b0;
      strobe_q    <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      prime_q     <= prime_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      armed_q     <= armed_d;
      started_q   <= started_d;
      held_q      <= held_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      sdata_q     <= sdata_d;
      strobe_q    <= strobe_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign sdata          = sdata_q;
  assign in_ready       = in_ready_q;
  assign frame_strobe   = strobe_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed bench for i2s_tx_fifo. Two instances share the
// stimulus: the default configuration and one with a 2-bit underrun counter.
// Frames are 48 kHz-style, 32 bclk per slot, lrclk changing on bclk falling
// edges; sdata is sampled just before each bclk rising edge.
`timescale 1ns/1ps
module tb_i2s_tx_fifo;

  localparam int HALF = 163;

  logic        clk;
  logic        resetn;
  logic        bclk;
  logic        lrclk;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        in_valid;
  logic        sdata;
  logic        in_ready;
  logic        frame_strobe;
  logic [15:0] ucount;
  logic        sdata2;
  logic        in_ready2;
  logic        frame_strobe2;
  logic [1:0]  ucount2;

  int total;
  int bad;
  int strobes;
  int strobes2;

  i2s_tx_fifo dut (
    .clk(clk), .resetn(resetn), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .frame_strobe(frame_strobe), .underrun_count(ucount)
  );

  i2s_tx_fifo #(.BITSIZE(16), .CNTSIZE(2)) dut2 (
    .clk(clk), .resetn(resetn), .bclk(bclk), .lrclk(lrclk), .sdata(sdata2),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready2), .frame_strobe(frame_strobe2), .underrun_count(ucount2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_strobe)  strobes++;
    if (frame_strobe2) strobes2++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One slot of n bclk periods; lrclk takes its new level on the first falling edge.
  task automatic slot(input logic lr, input int n, output logic [31:0] b1, output logic [31:0] b2);
    b1 = '0;
    b2 = '0;
    for (int b = 0; b < n; b++) begin
      bclk = 1'b0;
      if (b == 0) lrclk = lr;
      #HALF;
      b1[31-b] = sdata;
      b2[31-b] = sdata2;
      bclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    logic [31:0] a, b, c, d;
    logic [31:0] el, er;
    el = {1'b0, l, 15'b0};
    er = {1'b0, r, 15'b0};
    slot(1'b0, 32, a, b);
    slot(1'b1, 32, c, d);
    check({tag, "_left"}, 64'(a), 64'(el));
    check({tag, "_right"}, 64'(c), 64'(er));
    check({tag, "_left2"}, 64'(b), 64'(el));
    check({tag, "_right2"}, 64'(d), 64'(er));
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic exp_rdy, input string tag);
    @(negedge clk);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check(tag, 64'(in_ready), 64'(exp_rdy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    int s0;
    total    = 0;
    bad      = 0;
    strobes  = 0;
    strobes2 = 0;
    resetn   = 1'b0;
    bclk     = 1'b1;
    lrclk    = 1'b1;
    in_left  = '0;
    in_right = '0;
    in_valid = 1'b0;

    // Reset values, then in_ready rising on the first edge after release.
    repeat (3) @(negedge clk);
    check("rst_sdata", 64'(sdata), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_ready2", 64'(in_ready2), 64'(0));
    check("rst_strobe", 64'(frame_strobe), 64'(0));
    check("rst_ucount", 64'(ucount), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'(1));

    // No push: five silent frames, never armed.
    s0 = strobes;
    for (int f = 0; f < 5; f++) run_frame("idle", 16'h0000, 16'h0000);
    check("idle_ucount", 64'(ucount), 64'(0));
    check("idle_strobes", 64'(strobes - s0), 64'(5));

    // Single pair, single frame.
    do_reset();
    push(16'h8001, 16'h7FFE, 1'b1, "p1_ready");
    s0 = strobes;
    run_frame("basic", 16'h8001, 16'h7FFE);
    check("basic_strobes", 64'(strobes - s0), 64'(1));
    check("basic_ucount", 64'(ucount), 64'(0));

    // Fill the FIFO; third pair is refused and never played.
    do_reset();
    push(16'h0F0F, 16'hF0F0, 1'b1, "fill1_ready");
    push(16'h3C3C, 16'hC3C3, 1'b0, "fill2_ready");
    push(16'hFFFF, 16'hFFFF, 1'b0, "fill3_ready");
    run_frame("fill_f1", 16'h0F0F, 16'hF0F0);
    check("fill_ready_after_pop", 64'(in_ready), 64'(1));
    run_frame("fill_f2", 16'h3C3C, 16'hC3C3);
    run_frame("fill_f3", 16'h3C3C, 16'hC3C3);
    check("fill_ucount", 64'(ucount), 64'(1));

    // Repeat on starvation, and counter saturation in the narrow instance.
    do_reset();
    push(16'h1234, 16'hABCD, 1'b1, "rep_ready");
    s0 = strobes2;
    for (int f = 0; f < 3; f++) run_frame("rep", 16'h1234, 16'hABCD);
    check("rep_ucount", 64'(ucount), 64'(2));
    check("rep_ucount2", 64'(ucount2), 64'(2));
    for (int f = 0; f < 3; f++) run_frame("starve", 16'h1234, 16'hABCD);
    check("starve_ucount", 64'(ucount), 64'(5));
    check("sat_ucount2", 64'(ucount2), 64'(3));
    check("starve_strobes2", 64'(strobes2 - s0), 64'(6));

    // Reset in the middle of a left word.
    do_reset();
    push(16'hA5A5, 16'h5A5A, 1'b1, "mid_ready");
    slot(1'b0, 9, a, b);
    check("mid_prefix", 64'(a[31:23]), 64'({1'b0, 8'hA5}));
    resetn = 1'b0;
    #1;
    check("mid_rst_sdata", 64'(sdata), 64'(0));
    check("mid_rst_ready", 64'(in_ready), 64'(0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 64'(in_ready), 64'(1));
    slot(1'b0, 23, a, b);
    check("mid_rest_left", 64'(a), 64'(0));
    slot(1'b1, 32, a, b);
    check("mid_right", 64'(a), 64'(0));
    check("mid_right2", 64'(b), 64'(0));
    run_frame("mid_empty", 16'h0000, 16'h0000);
    check("mid_ucount", 64'(ucount), 64'(0));
    push(16'h4321, 16'h8765, 1'b1, "mid_fresh_ready");
    run_frame("mid_fresh", 16'h4321, 16'h8765);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 Parameter BITSIZE, default 16, SHALL set the sample word width per channel.
REQ-002 Parameter CNTSIZE, default 16, SHALL set the underrun counter width.
REQ-003 clk  in  1  system clock (OSC, 49.152 MHz); the only clock; all logic SHALL be on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 bclk  in  1  codec bit clock (codec is master), asynchronous to clk.
REQ-006 lrclk  in  1  codec DAC word clock, asynchronous to clk; low = left, high = right.
REQ-007 sdata  out  1  I2S serial data to codec (DACDAT).
REQ-008 in_left  in  BITSIZE  signed left sample.
REQ-009 in_right  in  BITSIZE  signed right sample.
REQ-010 in_valid  in  1  upstream stereo pair valid.
REQ-011 in_ready  out  1  block can accept a pair.
REQ-012 frame_strobe  out  1  one-clk pulse when a left word is loaded.
REQ-013 underrun_count  out  CNTSIZE  frames sent without a fresh pair, saturating.

Function
REQ-014 bclk and lrclk SHALL each pass a 2-flop synchronizer plus a third delay flop; edges SHALL be detected from stages 2 and 3.
REQ-015 Operation SHALL be correct for clk >= 4x bclk frequency.
REQ-016 Buffer SHALL be a 2-entry FIFO of stereo pairs (2*BITSIZE wide).
REQ-017 in_ready SHALL be high exactly when the registered occupancy < 2.
REQ-018 A pair SHALL be accepted on a clk edge with in_valid && in_ready; pairs offered while in_ready is low SHALL be ignored.
REQ-019 Push and pop on the same clk edge SHALL leave occupancy unchanged and keep FIFO order.
REQ-020 On a synchronized lrclk falling edge the FIFO SHALL be popped into a held-pair register if non-empty; the left word SHALL be loaded into the shift register; frame_strobe SHALL pulse for that one clk.
REQ-021 If the FIFO is empty at that edge, the previous held pair SHALL be repeated.
REQ-022 When armed, an empty FIFO at that edge SHALL increment underrun_count, saturating at all-ones.
REQ-023 The block SHALL become armed on the first accepted pair after reset.
REQ-024 On a synchronized lrclk rising edge the held right word SHALL be loaded; no pop SHALL occur.
REQ-025 At the load edge sdata SHALL be driven 0 and the bit counter cleared, giving the I2S one-bclk delay.
REQ-026 On each subsequent synchronized bclk falling edge, while bit counter < BITSIZE, sdata SHALL output the shift register MSB, shift left by one and increment the counter.
REQ-027 Once the counter reaches BITSIZE, sdata SHALL be 0 for the rest of the slot.
REQ-028 sdata SHALL be registered and update on the clk edge that detects the bclk falling edge.
REQ-029 A bclk edge coincident with an lrclk edge SHALL be treated as a load edge only, with no shift.
REQ-030 An lrclk edge arriving mid-word SHALL truncate the current word and load the new one.

Reset
REQ-031 While resetn is low: sdata=0, in_ready=0, frame_strobe=0, underrun_count=0; FIFO empty; held pair, shift register and counter=0; not armed; synchronizer flops=0.
REQ-032 in_ready SHALL rise on the first clk edge after resetn deasserts.
REQ-033 After reset deasserts mid-frame, sdata SHALL stay 0 until the first lrclk falling edge.
REQ-034 An lrclk edge present in the synchronizer at deassertion SHALL NOT produce a load.

Verification
REQ-035 Push L=0x8001, R=0x7FFE, then run a 48 kHz frame with 32 bclk/slot -> left slot bits 0,1000000000000001,0...; right slot 0,0111111111111110,0...; frame_strobe pulses once.
REQ-036 Push 3 pairs with no frames -> in_ready low after the 2nd; 3rd ignored; two frames play pairs 1 and 2 in order.
REQ-037 Push 1 pair, run 3 frames -> pair repeated 3 times; underrun_count=2.
REQ-038 Run 5 frames with no push after reset -> sdata all 0; underrun_count=0.
REQ-039 CNTSIZE=2, armed, 5 starved frames -> underrun_count stops at 3.
REQ-040 Assert resetn mid-left-word -> sdata=0 immediately; FIFO empty; output stays 0 until the next lrclk falling edge after a fresh push.
